// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: bus decode defaults, register map and STATUS layout.
package uart_pkg;

   localparam logic [31:0] ENTRY_START_DEF = 32'h3fffffe0;
   localparam logic [31:0] ENTRY_END_DEF   = 32'h3fffffef;

   localparam logic [1:0] OFF_DATA    = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_CONTROL = 2'd2;

   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_OVERRUN   = 1;
   localparam int ST_FRAME_ERR = 2;
   localparam int ST_COUNT_LSB = 4;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; flush beats push, push+pop together is legal even when full.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [7:0]    din,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic [7:0]    head
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_pop, w_push;

   assign empty = (r_count == '0);
   assign full  = (r_count == CW'(DEPTH));
   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

   assign w_pop  = pop & ~empty & ~flush;
   assign w_push = push & (~full | w_pop) & ~flush;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (clr || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: synchronizer, 8N1 receive FSM, receive FIFO and a 1-wait-state bus slave.
module uart_rx
   import uart_pkg::*;
#(
   parameter logic [31:0] ENTRY_START  = ENTRY_START_DEF,
   parameter logic [31:0] ENTRY_END    = ENTRY_END_DEF,
   parameter int          CLKS_PER_BIT = 33,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] address,
   inout  wire  [31:0] data,
   input  logic        request,
   input  logic        r_w,
   output logic        ready_out,
   input  logic        RxD,
   output logic        RxD_ready
);

   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_e         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_bit;
   logic [7:0]        r_shreg;
   logic              r_rx_s1, r_rx_s2, r_rx_prev;
   logic              r_push, r_frame_err, r_overrun;
   logic              r_sel_d;
   logic [31:0]       r_rd_q;

   logic              w_sel, w_first, w_pop, w_ctl_wr, w_flush, w_clr_err, w_ovr;
   logic              w_full, w_empty;
   logic [CW-1:0]     w_count;
   logic [7:0]        w_head;
   logic [1:0]        w_off;
   logic [31:0]       w_rd_data;

   // Bus decode; every action fires only on the first cycle of a selection.
   assign w_sel     = request && (address >= ENTRY_START) && (address <= ENTRY_END);
   assign w_off     = address[1:0];
   assign w_first   = w_sel & ~r_sel_d;
   assign w_pop     = w_first & ~r_w & (w_off == OFF_DATA) & ~w_empty;
   assign w_ctl_wr  = w_first & r_w & (w_off == OFF_CONTROL);
   assign w_flush   = w_ctl_wr & data[1];
   assign w_clr_err = w_ctl_wr & data[0];
   assign w_ovr     = r_push & w_full & ~w_pop & ~w_flush;

   assign ready_out = w_sel ? r_sel_d : 1'bz;
   assign data      = (w_sel & ~r_w) ? r_rd_q : 32'bz;
   assign RxD_ready = ~w_empty;

   always_comb begin
      w_rd_data = '0;
      case (w_off)
         OFF_DATA: if (!w_empty) w_rd_data[8:0] = {1'b1, w_head};
         OFF_STATUS: begin
            w_rd_data[ST_COUNT_LSB +: 4] = 4'(w_count);
            w_rd_data[ST_FRAME_ERR]      = r_frame_err;
            w_rd_data[ST_OVERRUN]        = r_overrun;
            w_rd_data[ST_NOT_EMPTY]      = ~w_empty;
         end
         default: w_rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_sel_d <= 1'b0;
         r_rd_q  <= '0;
      end else begin
         r_sel_d <= w_sel;
         if (w_first & ~r_w) r_rd_q <= w_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_rx_s1     <= 1'b1;
         r_rx_s2     <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_shreg     <= '0;
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_rx_s1   <= RxD;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
         r_push    <= 1'b0;
         // A new error event in the same cycle as a clear is kept.
         if (w_clr_err) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
         end
         if (w_ovr) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               r_bit <= '0;
               if (r_rx_prev && !r_rx_s2) r_state <= S_START;
            end
            S_START: begin
               if (r_cnt == HALF_BIT) begin
                  r_cnt   <= '0;
                  r_state <= r_rx_s2 ? S_IDLE : S_DATA;
               end else r_cnt <= r_cnt + 1'b1;
            end
            S_DATA: begin
               if (r_cnt == FULL_BIT) begin
                  r_cnt   <= '0;
                  r_shreg <= {r_rx_s2, r_shreg[7:1]};
                  r_bit   <= r_bit + 1'b1;
                  if (r_bit == 3'd7) r_state <= S_STOP;
               end else r_cnt <= r_cnt + 1'b1;
            end
            S_STOP: begin
               if (r_cnt == FULL_BIT) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  if (r_rx_s2) r_push      <= 1'b1;
                  else         r_frame_err <= 1'b1;
               end else r_cnt <= r_cnt + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (r_push),
      .pop   (w_pop),
      .flush (w_flush),
      .din   (r_shreg),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count),
      .head  (w_head)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames feed an expected-byte queue, bus reads pop and compare.
module tb_uart_rx;

   localparam int          CPB  = 33;
   localparam logic [31:0] BASE = 32'h3fffffe0;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] address = '0;
   logic        request = 1'b0;
   logic        r_w = 1'b0;
   logic        RxD = 1'b1;
   wire         ready_out;
   wire         RxD_ready;
   wire  [31:0] data;
   logic [31:0] tb_data = '0;
   logic        tb_oe = 1'b0;

   assign data = tb_oe ? tb_data : 32'bz;

   uart_rx dut (
      .clk       (clk),
      .clr       (clr),
      .address   (address),
      .data      (data),
      .request   (request),
      .r_w       (r_w),
      .ready_out (ready_out),
      .RxD       (RxD),
      .RxD_ready (RxD_ready)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic       exp_fe = 1'b0;
   logic       exp_ov = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = '0;
      s[7:4] = 4'(exp_q.size());
      s[2]   = exp_fe;
      s[1]   = exp_ov;
      s[0]   = (exp_q.size() != 0);
      return s;
   endfunction

   task automatic bit_time(input logic v);
      RxD = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      @(negedge clk);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop);
      RxD = 1'b1;
      repeat (3) @(negedge clk);
      if (!stop)                  exp_fe = 1'b1;
      else if (exp_q.size() < 8)  exp_q.push_back(b);
      else                        exp_ov = 1'b1;
   endtask

   task automatic bus_rd(input logic [1:0] off, output logic [31:0] d,
                         output logic rdy0, output logic rdy1);
      @(negedge clk);
      address = BASE + {30'b0, off};
      r_w     = 1'b0;
      request = 1'b1;
      #1 rdy0 = ready_out;
      @(negedge clk);
      rdy1    = ready_out;
      d       = data;
      request = 1'b0;
      address = '0;
   endtask

   task automatic bus_wr(input logic [1:0] off, input logic [31:0] v);
      @(negedge clk);
      address = BASE + {30'b0, off};
      r_w     = 1'b1;
      request = 1'b1;
      tb_data = v;
      tb_oe   = 1'b1;
      @(negedge clk);
      request = 1'b0;
      tb_oe   = 1'b0;
      r_w     = 1'b0;
      address = '0;
      if (off == 2'd2 && v[0]) begin exp_fe = 1'b0; exp_ov = 1'b0; end
      if (off == 2'd2 && v[1]) exp_q.delete();
   endtask

   task automatic rd_status(input string tag);
      logic [31:0] d;
      logic r0, r1;
      bus_rd(2'd1, d, r0, r1);
      chk(tag, d, exp_status());
   endtask

   task automatic rd_data(input string tag);
      logic [31:0] d, e;
      logic r0, r1;
      e = '0;
      if (exp_q.size() != 0) e = {23'b0, 1'b1, exp_q.pop_front()};
      bus_rd(2'd0, d, r0, r1);
      chk(tag, d, e);
   endtask

   initial begin
      logic [31:0] d;
      logic r0, r1;

      repeat (4) @(negedge clk);
      clr = 1'b0;
      chk("rst_rxready", {31'b0, RxD_ready}, 32'h0);
      rd_status("rst_status");

      // Single frame, bus handshake timing and RxD_ready fall after the pop.
      send_frame(8'h55, 1'b1);
      chk("f55_rxready", {31'b0, RxD_ready}, 32'h1);
      bus_rd(2'd0, d, r0, r1);
      chk("f55_rdy_c1", {31'b0, r0}, 32'h0);
      chk("f55_rdy_c2", {31'b0, r1}, 32'h1);
      chk("f55_data", d, 32'h155);
      void'(exp_q.pop_front());
      chk("f55_rxready_fall", {31'b0, RxD_ready}, 32'h0);

      rd_data("empty_data");
      rd_status("empty_status");

      // Overflow: nine frames into an eight-deep FIFO.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
      bus_rd(2'd1, d, r0, r1);
      chk("ovr_status", d, 32'h83);
      for (int i = 0; i < 8; i++) rd_data($sformatf("ovr_data%0d", i));
      rd_status("ovr_drained");
      bus_wr(2'd2, 32'h1);
      rd_status("ovr_cleared");

      // Framing error.
      send_frame(8'hA5, 1'b0);
      bus_rd(2'd1, d, r0, r1);
      chk("fe_status", d, 32'h4);
      bus_wr(2'd2, 32'h1);
      bus_rd(2'd1, d, r0, r1);
      chk("fe_cleared", d, 32'h0);

      // Short low glitch must be rejected.
      @(negedge clk);
      RxD = 1'b0;
      repeat (10) @(negedge clk);
      RxD = 1'b1;
      repeat (40) @(negedge clk);
      rd_status("glitch_status");

      // Reset during bit 4 abandons the frame.
      @(negedge clk);
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b0);
      RxD = 1'b1;
      repeat (16) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (400) @(negedge clk);
      send_frame(8'h3C, 1'b1);
      bus_rd(2'd1, d, r0, r1);
      chk("clr_status", d, 32'h11);
      rd_data("clr_data");
      rd_status("clr_after");

      // Back-to-back frames then a flush.
      send_frame(8'hC3, 1'b1);
      send_frame(8'h7E, 1'b1);
      rd_status("two_status");
      bus_wr(2'd2, 32'h2);
      rd_status("flush_status");
      chk("flush_rxready", {31'b0, RxD_ready}, 32'h0);

      // Unmapped offsets read zero; writes to DATA/STATUS are ignored.
      send_frame(8'h81, 1'b1);
      bus_wr(2'd0, 32'h3);
      bus_wr(2'd1, 32'h3);
      bus_rd(2'd3, d, r0, r1);
      chk("off3_read", d, 32'h0);
      bus_rd(2'd2, d, r0, r1);
      chk("off2_read", d, 32'h0);
      rd_data("last_data");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter ENTRY_START, default 32'h3fffffe0: lowest decoded bus address.
REQ-002 SHALL have parameter ENTRY_END, default 32'h3fffffef: highest decoded bus address.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 33: clk cycles per bit (50 MHz / 1.5 Mbaud, rounded).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries; power of 2.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on posedge clk.
REQ-006 SHALL have port clr, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port address, input, 32: bus address.
REQ-008 SHALL have port data, inout, 32: bus data; driven only on a selected read, high-Z otherwise.
REQ-009 SHALL have port request, input, 1: bus request.
REQ-010 SHALL have port r_w, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port ready_out, output, 1: 1 when the access completes, high-Z when not selected.
REQ-012 SHALL have port RxD, input, 1: asynchronous serial line, idle high.
REQ-013 SHALL have port RxD_ready, output, 1: FIFO not empty.

Function
REQ-014 SHALL decode selected = request & ENTRY_START <= address <= ENTRY_END, combinationally; register offset = address[1:0].
REQ-015 SHALL hold ready_out at 0 on the first selected cycle and at 1 from the second consecutive selected cycle, giving 1-cycle latency.
REQ-016 SHALL, on the first selected read cycle, latch read data into rd_q and drive rd_q onto data while selected & ~r_w.
REQ-017 SHALL return on offset 0 (DATA) {23'b0, valid, byte[7:0]}; valid=1 with the FIFO head when not empty, all-zero when empty.
REQ-018 SHALL pop the FIFO exactly once per DATA read: on the first selected cycle, and only if not empty; holding request SHALL NOT pop again.
REQ-019 SHALL return on offset 1 (STATUS) {24'b0, count[3:0], 1'b0, frame_err, overrun, not_empty}.
REQ-020 SHALL, on a write to offset 2 (CONTROL) with data[0]=1, clear frame_err and overrun; data[1]=1 SHALL flush the FIFO.
REQ-021 SHALL ignore writes to offsets 0, 1 and 3, and SHALL return zero on reads of offsets 2 and 3.
REQ-022 SHALL pass RxD through a two-flop synchronizer (reset value 1) before any use.
REQ-023 SHALL implement states IDLE, START, DATA and STOP.
REQ-024 SHALL move IDLE->START on a synchronized 1->0 transition.
REQ-025 SHALL, in START, sample at count CLKS_PER_BIT/2 (16): low -> DATA, high -> IDLE (glitch rejected, nothing recorded).
REQ-026 SHALL, in DATA, sample 8 bits LSB-first every CLKS_PER_BIT cycles after the start-bit sample, then go to STOP.
REQ-027 SHALL, in STOP, sample once at mid-bit: 1 -> push the byte, 0 -> discard the byte and set frame_err (sticky); both go to IDLE immediately, so back-to-back frames are accepted.
REQ-028 SHALL, on a push to a full FIFO, drop the new byte, set overrun (sticky) and leave FIFO contents unchanged.
REQ-029 SHALL, on a simultaneous push and pop, do both, with count unchanged, including when full.
REQ-030 SHALL give a flush on the same cycle as a push priority to the flush, leaving the FIFO empty.
REQ-031 SHALL use wrapping FIFO pointers of width log2(FIFO_DEPTH), with count of width log2(FIFO_DEPTH)+1.

Reset
REQ-032 SHALL, on clr=1 at posedge clk, force state IDLE, bit counters 0, FIFO empty, frame_err=0, overrun=0, rd_q=0, synchronizer=11, RxD_ready=0.
REQ-033 SHALL, when clr asserts mid-frame, abandon the frame without a push or error flag.
REQ-034 SHALL leave ready_out and data at high-Z during reset unless a selection is active.

Structure
REQ-035 SHALL place address defaults, register offsets (DATA=0, STATUS=1, CONTROL=2) and STATUS bit positions in shared package uart_pkg.
REQ-036 SHALL implement the FIFO as sub-module uart_rx_fifo (push, pop, flush, full, empty, count, head).
REQ-037 SHALL keep the bus interface and the receive FSM in uart_rx.

Verification
REQ-038 SHALL verify: frame 0x55 at 33 clk/bit, then DATA read -> ready_out=1 on 2nd cycle, data=0x00000155, RxD_ready falls one cycle later.
REQ-039 SHALL verify: DATA read with FIFO empty -> data=0x00000000, count stays 0, no error flags set.
REQ-040 SHALL verify: 9 frames 0x01..0x09 with no reads -> STATUS=0x00000083 (count 8, overrun, not_empty); 8 DATA reads return 0x101..0x108.
REQ-041 SHALL verify: frame 0xA5 with stop bit 0 -> STATUS=0x00000004, FIFO empty; CONTROL write 0x1 -> STATUS=0x00000000.
REQ-042 SHALL verify: 10-cycle low glitch on RxD -> FSM returns to IDLE, STATUS=0x00000000.
REQ-043 SHALL verify: clr pulsed during bit 4 of a frame, then a clean frame 0x3C -> single entry 0x13C, no flags.
